// File: rtl/mau_window_ctrl.sv
// rtl/mau_window_ctrl.sv - raster sequencer and window-valid generator for the 7x7 line-memory window unit
module mau_window_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int WIN        = 7,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic          s_sof,
  output logic          s_ready,
  output logic          mau_enable,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [CW-1:0] center_row,
  output logic [CW-1:0] center_col,
  output logic          win_first,
  output logic          win_last,
  output logic          frame_done,
  output logic          err_sof
);

  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] EDGE     = CW'(WIN - 1);
  localparam logic [CW-1:0] HALF     = CW'(WIN / 2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] row, col;
  logic [CW-1:0] pix_row, pix_col;
  logic          slot_free;
  logic          pix_final;
  logic          pix_fill_end;
  logic          completes;
  logic          mid_sof;

  // A SOF pixel is always (0,0) of a new frame, whatever the counters say.
  assign slot_free    = !win_valid || win_ready;
  assign pix_row      = s_sof ? '0 : row;
  assign pix_col      = s_sof ? '0 : col;
  assign pix_final    = (pix_row == LAST_ROW) && (pix_col == LAST_COL);
  assign pix_fill_end = (pix_row == EDGE) && (pix_col == EDGE);
  assign completes    = mau_enable && (pix_row >= EDGE) && (pix_col >= EDGE);
  assign mid_sof      = mau_enable && s_sof && ((state == FILL) || (state == RUN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mau_enable) state_nxt = FILL;
      FILL, RUN: begin
        if (mau_enable) begin
          if (s_sof)                              state_nxt = FILL;
          else if (pix_final)                     state_nxt = DONE;
          else if (state == FILL && pix_fill_end) state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = 1'b0;
    mau_enable = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        s_ready    = slot_free;
        mau_enable = s_valid && slot_free && s_sof;
      end
      FILL, RUN: begin
        s_ready    = slot_free;
        mau_enable = s_valid && slot_free;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (mau_enable) begin
      if (pix_final) begin
        row <= '0;
        col <= '0;
      end else if (pix_col == LAST_COL) begin
        row <= pix_row + CW'(1);
        col <= '0;
      end else begin
        row <= pix_row;
        col <= pix_col + CW'(1);
      end
    end
  end

  // A newly completed window overwrites a slot being drained in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid  <= 1'b0;
      center_row <= '0;
      center_col <= '0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      err_sof <= mid_sof;
      if (completes) begin
        win_valid  <= 1'b1;
        center_row <= pix_row - HALF;
        center_col <= pix_col - HALF;
        win_first  <= pix_fill_end;
        win_last   <= pix_final;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mau_window_ctrl.sv
// tb/tb_mau_window_ctrl.sv - randomized bench for mau_window_ctrl against a raster-index reference model
module tb_mau_window_ctrl;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int WIN  = 7;
  localparam int CW   = 10;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          win_ready = 1'b0;
  logic          s_ready, mau_enable, win_valid, win_first, win_last, frame_done, err_sof;
  logic [CW-1:0] center_row, center_col;

  mau_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .WIN(WIN), .CW(CW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .mau_enable(mau_enable), .win_valid(win_valid), .win_ready(win_ready),
    .center_row(center_row), .center_col(center_col), .win_first(win_first),
    .win_last(win_last), .frame_done(frame_done), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: position is a raster index into the frame.
  bit m_in_frame, m_done, m_wv, m_first, m_last, m_err, m_acc_now;
  int m_idx, m_row, m_col;

  // Observations for the directed scenario checks.
  int o_acc, o_first_acc, o_fd_acc, n_fd, n_err, n_men, n_rdy_lo;
  int wq_row[$], wq_col[$], wq_last[$];

  task automatic clr_stats();
    o_acc = 0; o_first_acc = -1; o_fd_acc = -1;
    n_fd = 0; n_err = 0; n_men = 0; n_rdy_lo = 0;
    wq_row.delete(); wq_col.delete(); wq_last.delete();
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_done = 0; m_wv = 0; m_first = 0; m_last = 0; m_err = 0;
    m_idx = 0; m_row = 0; m_col = 0; m_acc_now = 0;
  endtask

  task automatic cycle(input bit sv, input bit sof, input bit wr);
    bit e_ready, e_men, comp;
    int p;
    @(negedge clk);
    s_valid = sv; s_sof = sof; win_ready = wr;
    #1;
    e_ready = !m_done && (!m_wv || wr);
    e_men   = sv && e_ready && (m_in_frame || sof);
    check("s_ready", s_ready, e_ready);
    check("mau_enable", mau_enable, e_men);
    check("win_valid", win_valid, m_wv);
    if (m_wv) begin
      check("center_row", center_row, m_row);
      check("center_col", center_col, m_col);
      check("win_first", win_first, m_first);
      check("win_last", win_last, m_last);
    end
    check("frame_done", frame_done, m_done);
    check("err_sof", err_sof, m_err);

    if (win_valid && o_first_acc < 0) o_first_acc = o_acc;
    if (frame_done) begin
      n_fd++;
      if (o_fd_acc < 0) o_fd_acc = o_acc;
    end
    if (err_sof) n_err++;
    if (mau_enable) n_men++;
    if (!s_ready) n_rdy_lo++;
    if (win_valid && wr) begin
      wq_row.push_back(int'(center_row));
      wq_col.push_back(int'(center_col));
      wq_last.push_back(int'(win_last));
    end

    m_acc_now = sv && e_ready;
    if (m_acc_now) o_acc++;
    comp   = 0;
    m_err  = e_men && sof && m_in_frame;
    m_done = 0;
    if (e_men) begin
      p    = sof ? 0 : m_idx;
      comp = (p / W >= WIN - 1) && (p % W >= WIN - 1);
      if (comp) begin
        m_row   = p / W - WIN / 2;
        m_col   = p % W - WIN / 2;
        m_first = (p == (WIN - 1) * W + (WIN - 1));
        m_last  = (p == NPIX - 1);
      end
      if (p == NPIX - 1) begin
        m_in_frame = 0; m_done = 1; m_idx = 0;
      end else begin
        m_in_frame = 1; m_idx = p + 1;
      end
    end
    if (comp)    m_wv = 1;
    else if (wr) m_wv = 0;
  endtask

  task automatic reset_dut(input bit expect_wv);
    @(posedge clk);
    #1;
    if (expect_wv) check("wv_before_reset", win_valid, 1);
    s_valid = 0; s_sof = 0;
    reset = 1;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_mau_enable", mau_enable, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_center", {center_row, center_col}, 0);
    check("rst_first_last", {win_first, win_last}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sof", err_sof, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Upstream source: sp is the raster index of the pixel currently offered.
  task automatic stream(input int frames, input int pv, input int pr, input int inject,
                        input bit hold_first, input int stop_acc);
    int sp = 0, done_f = 0, guard = 0, hold = 0;
    bit injected = 0, did_hold = 0, sv, sof, wr;
    while (done_f < frames && guard < 5000) begin
      guard++;
      if (stop_acc > 0 && o_acc >= stop_acc) break;
      if (hold_first && m_wv && m_first && !did_hold) begin
        hold = 5; did_hold = 1;
      end
      sv  = ($urandom_range(99) < pv);
      sof = (sp == 0) || (!injected && sp == inject);
      wr  = (hold > 0) ? 1'b0 : ($urandom_range(99) < pr);
      if (hold > 0) hold--;
      cycle(sv, sof, wr);
      if (m_acc_now) begin
        if (sof && sp != 0) injected = 1;
        sp = (sof ? 0 : sp) + 1;
        if (sp == NPIX) begin
          sp = 0; done_f++;
        end
      end
    end
    check("stream_timeout", (guard >= 5000), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);
  endtask

  task automatic check_wins(input string t, input int nframes);
    int er[4] = '{3, 3, 4, 4};
    int ec[4] = '{3, 4, 3, 4};
    check({t, "_nwin"}, wq_row.size(), 4 * nframes);
    for (int i = 0; i < wq_row.size() && i < 4 * nframes; i++) begin
      check({t, "_row"}, wq_row[i], er[i % 4]);
      check({t, "_col"}, wq_col[i], ec[i % 4]);
      check({t, "_last"}, wq_last[i], (i % 4 == 3));
    end
  endtask

  initial begin
    model_reset();
    clr_stats();
    reset_dut(0);

    // Continuous stream, no backpressure.
    clr_stats();
    stream(1, 100, 100, -1, 0, 0);
    drain();
    check("s1_first_acc", o_first_acc, 55);
    check("s1_done_acc", o_fd_acc, 64);
    check("s1_nfd", n_fd, 1);
    check_wins("s1", 1);

    // Backpressure held for 5 cycles on the first window.
    clr_stats();
    stream(1, 100, 100, -1, 1, 0);
    drain();
    check("s2_nmen", n_men, 64);
    check("s2_rdy_lo", n_rdy_lo, 6);
    check_wins("s2", 1);

    // Pixels without SOF in IDLE are dropped.
    clr_stats();
    for (int i = 0; i < 3; i++) cycle(1, 0, 1);
    check("s3_drop_men", n_men, 0);
    stream(1, 100, 100, -1, 0, 0);
    drain();
    check("s3_first_acc", o_first_acc, 58);
    check("s3_nmen", n_men, 64);
    check_wins("s3", 1);

    // Mid-frame SOF at raster pixel 20.
    clr_stats();
    stream(1, 100, 100, 20, 0, 0);
    drain();
    check("s4_nerr", n_err, 1);
    check("s4_first_acc", o_first_acc, 75);
    check("s4_nfd", n_fd, 1);
    check_wins("s4", 1);

    // Reset during RUN with a window pending, then a clean frame.
    clr_stats();
    stream(1, 100, 100, -1, 0, 56);
    reset_dut(1);
    clr_stats();
    stream(1, 100, 100, -1, 0, 0);
    drain();
    check("s5_first_acc", o_first_acc, 55);
    check_wins("s5", 1);

    // Two back-to-back frames: only the DONE cycles deassert s_ready.
    clr_stats();
    stream(2, 100, 100, -1, 0, 0);
    drain();
    check("s6_rdy_lo", n_rdy_lo, 2);
    check("s6_nfd", n_fd, 2);
    check_wins("s6", 2);

    // Random valid and ready.
    clr_stats();
    stream(3, 70, 60, -1, 0, 0);
    drain();
    check("s7_nfd", n_fd, 3);
    check("s7_nmen", n_men, 3 * NPIX);
    check_wins("s7", 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
